tdc_meas_ctrl: RTL and testbench

Measurement sequencer for the TDC delay-line core. It clears and arms the capture flops, then waits for the stop capture with a timeout. It converts each thermometer code to a bubble-tolerant binary count and averages 2^AVG_LOG2 samples into one result. It sits between the user-pin decode (ui_in request bit) and the TDC core, and its result feeds the uo_out output mux.

---
 rtl/tdc_meas_ctrl.sv | 151 +++++++++++++++
 tb/tb_tdc_meas_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/tdc_meas_ctrl.sv
// TDC measurement sequencer: clears/arms the delay line, waits for the stop
// capture with a timeout, popcounts each thermometer code and averages samples.
module tdc_meas_ctrl #(
  parameter int unsigned TAPS     = 16,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ena,
  input  logic            meas_req,
  output logic            tdc_clr,
  output logic            tdc_arm,
  input  logic            tdc_valid,
  input  logic [TAPS-1:0] tdc_code,
  output logic            busy,
  output logic [7:0]      result,
  output logic            result_valid,
  output logic            timeout,
  output logic            overflow
);

  localparam int unsigned CW  = $clog2(TAPS + 1);
  localparam int unsigned AW  = CW + AVG_LOG2;
  localparam int unsigned SCW = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam int unsigned TW  = 8;

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_ARM     = 3'd2;
  localparam logic [2:0] S_WAIT    = 3'd3;
  localparam logic [2:0] S_CAPTURE = 3'd4;
  localparam logic [2:0] S_ACCUM   = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  logic [2:0]     state, state_nxt;
  logic [TW-1:0]  timer, timer_nxt;
  logic [SCW-1:0] sample_cnt, sample_cnt_nxt;
  logic [CW-1:0]  sample, sample_nxt;
  logic [AW-1:0]  acc, acc_nxt;
  logic [7:0]     result_nxt;
  logic           result_valid_nxt, timeout_nxt, overflow_nxt;
  logic [CW-1:0]  code_ones_c;
  logic [AW-1:0]  acc_sum_c;

  // Popcount rather than leading-one search so bubbles in the code are harmless
  always_comb begin
    code_ones_c = '0;
    for (int i = 0; i < int'(TAPS); i++) begin
      code_ones_c = code_ones_c + CW'(tdc_code[i]);
    end
  end

  assign acc_sum_c = acc + AW'(sample);

  always_comb begin
    state_nxt        = state;
    timer_nxt        = timer;
    sample_cnt_nxt   = sample_cnt;
    sample_nxt       = sample;
    acc_nxt          = acc;
    result_nxt       = result;
    result_valid_nxt = 1'b0;
    timeout_nxt      = timeout;
    overflow_nxt     = overflow;

    case (state)
      S_IDLE: begin
        if (meas_req) begin
          state_nxt      = S_CLEAR;
          timeout_nxt    = 1'b0;
          overflow_nxt   = 1'b0;
          acc_nxt        = '0;
          sample_cnt_nxt = '0;
        end
      end
      S_CLEAR: state_nxt = S_ARM;
      S_ARM: begin
        state_nxt = S_WAIT;
        timer_nxt = '0;
      end
      S_WAIT: begin
        timer_nxt = timer + TW'(1);
        if (tdc_valid) begin
          state_nxt = S_CAPTURE;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          state_nxt   = S_IDLE;
          timeout_nxt = 1'b1;
        end
      end
      S_CAPTURE: begin
        sample_nxt = code_ones_c;
        if (code_ones_c == CW'(TAPS)) overflow_nxt = 1'b1;
        state_nxt = S_ACCUM;
      end
      S_ACCUM: begin
        acc_nxt = acc_sum_c;
        if (sample_cnt == SCW'((1 << AVG_LOG2) - 1)) begin
          state_nxt        = S_DONE;
          result_nxt       = 8'(acc_sum_c >> AVG_LOG2);
          result_valid_nxt = 1'b1;
        end else begin
          sample_cnt_nxt = sample_cnt + SCW'(1);
          state_nxt      = S_CLEAR;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    // Disable aborts without publishing anything or touching sticky flags
    if (!ena) begin
      state_nxt        = S_IDLE;
      result_nxt       = result;
      result_valid_nxt = 1'b0;
      timeout_nxt      = timeout;
      overflow_nxt     = overflow;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      timer        <= '0;
      sample_cnt   <= '0;
      sample       <= '0;
      acc          <= '0;
      tdc_clr      <= 1'b0;
      tdc_arm      <= 1'b0;
      busy         <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
      timeout      <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      state        <= state_nxt;
      timer        <= timer_nxt;
      sample_cnt   <= sample_cnt_nxt;
      sample       <= sample_nxt;
      acc          <= acc_nxt;
      tdc_clr      <= (state_nxt == S_CLEAR);
      tdc_arm      <= (state_nxt == S_ARM) || (state_nxt == S_WAIT);
      busy         <= (state_nxt != S_IDLE);
      result       <= result_nxt;
      result_valid <= result_valid_nxt;
      timeout      <= timeout_nxt;
      overflow     <= overflow_nxt;
    end
  end

endmodule

// File: tb/tb_tdc_meas_ctrl.sv
// Directed bench for tdc_meas_ctrl: an averaging instance and a single-sample
// instance share clock, reset, enable and the TDC capture inputs.
module tb_tdc_meas_ctrl;

  logic        clk, rst, ena, tdc_valid;
  logic [15:0] tdc_code;
  logic        req_avg, req_one;

  logic       clr_avg, arm_avg, busy_avg, rv_avg, to_avg, ovf_avg;
  logic [7:0] res_avg;
  logic       clr_one, arm_one, busy_one, rv_one, to_one, ovf_one;
  logic [7:0] res_one;

  int n_checks = 0;
  int n_errors = 0;
  int n_clr_avg = 0, n_clr_one = 0, n_rv_avg = 0, n_rv_one = 0;
  int snap_clr, snap_rv;

  tdc_meas_ctrl #(.TAPS(16), .AVG_LOG2(2), .TIMEOUT(20)) u_avg (
    .clk(clk), .rst(rst), .ena(ena), .meas_req(req_avg),
    .tdc_clr(clr_avg), .tdc_arm(arm_avg), .tdc_valid(tdc_valid), .tdc_code(tdc_code),
    .busy(busy_avg), .result(res_avg), .result_valid(rv_avg),
    .timeout(to_avg), .overflow(ovf_avg)
  );

  tdc_meas_ctrl #(.TAPS(16), .AVG_LOG2(0), .TIMEOUT(20)) u_one (
    .clk(clk), .rst(rst), .ena(ena), .meas_req(req_one),
    .tdc_clr(clr_one), .tdc_arm(arm_one), .tdc_valid(tdc_valid), .tdc_code(tdc_code),
    .busy(busy_one), .result(res_one), .result_valid(rv_one),
    .timeout(to_one), .overflow(ovf_one)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (clr_avg === 1'b1) n_clr_avg++;
    if (clr_one === 1'b1) n_clr_one++;
    if (rv_avg === 1'b1)  n_rv_avg++;
    if (rv_one === 1'b1)  n_rv_one++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entry: selected DUT in CLEAR. Exit: DUT in the cycle after ACCUM.
  task automatic do_sample(input bit sel, input logic [15:0] code, input int k);
    chk("clr_pulse", sel ? clr_one : clr_avg, 1);
    tick();
    req_avg = 1'b0;
    req_one = 1'b0;
    chk("arm_in_arm", sel ? arm_one : arm_avg, 1);
    tick();
    tdc_code = code;
    for (int i = 0; i < k; i++) tick();
    chk("arm_in_wait", sel ? arm_one : arm_avg, 1);
    tdc_valid = 1'b1;
    tick();
    tdc_valid = 1'b0;
    chk("arm_in_capture", sel ? arm_one : arm_avg, 0);
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; tdc_valid = 1'b0; tdc_code = '0;
    req_avg = 1'b0; req_one = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset values
    chk("rst_clr", clr_avg, 0);
    chk("rst_arm", arm_avg, 0);
    chk("rst_busy", busy_avg, 0);
    chk("rst_result", res_avg, 0);
    chk("rst_rv", rv_avg, 0);
    chk("rst_timeout", to_avg, 0);
    chk("rst_overflow", ovf_avg, 0);
    tick();

    // Single sample, code 00FF at k=3 -> 8, result_valid in cycle 9
    snap_clr = n_clr_one; snap_rv = n_rv_one;
    req_one = 1'b1;
    tick();
    chk("one_busy", busy_one, 1);
    do_sample(1'b1, 16'h00FF, 3);
    chk("one_rv", rv_one, 1);
    chk("one_result", res_one, 8);
    tick();
    chk("one_busy_drop", busy_one, 0);
    chk("one_rv_pulse", rv_one, 0);
    chk("one_clr_count", n_clr_one - snap_clr, 1);
    chk("one_rv_count", n_rv_one - snap_rv, 1);

    // Averaging 4,5,6,7 -> acc 22, result 5, with an ignored mid-sequence request
    snap_clr = n_clr_avg; snap_rv = n_rv_avg;
    req_avg = 1'b1;
    tick();
    do_sample(1'b0, 16'h000F, 0);
    do_sample(1'b0, 16'h001F, 1);
    req_avg = 1'b1;
    do_sample(1'b0, 16'h003F, 2);
    do_sample(1'b0, 16'h007F, 0);
    chk("avg_rv", rv_avg, 1);
    chk("avg_result", res_avg, 5);
    tick();
    chk("avg_busy_drop", busy_avg, 0);
    chk("avg_clr_count", n_clr_avg - snap_clr, 4);
    chk("avg_rv_count", n_rv_avg - snap_rv, 1);
    chk("avg_overflow", ovf_avg, 0);

    // Timeout after 20 WAIT cycles, result held
    snap_rv = n_rv_avg;
    req_avg = 1'b1;
    tick();
    req_avg = 1'b0;
    tick(); tick();
    for (int i = 0; i < 19; i++) tick();
    chk("to_last_wait_busy", busy_avg, 1);
    chk("to_last_wait_flag", to_avg, 0);
    tick();
    chk("to_flag", to_avg, 1);
    chk("to_busy", busy_avg, 0);
    chk("to_arm", arm_avg, 0);
    chk("to_result_held", res_avg, 5);
    chk("to_no_rv", n_rv_avg - snap_rv, 0);

    // Next request clears timeout; bubble code 00F7 counts 7 -> (7+7+7+8)>>2 = 7
    req_avg = 1'b1;
    tick();
    chk("to_cleared", to_avg, 0);
    do_sample(1'b0, 16'h00F7, 0);
    do_sample(1'b0, 16'h00F7, 1);
    do_sample(1'b0, 16'h00F7, 0);
    do_sample(1'b0, 16'h00FF, 0);
    chk("bubble_result", res_avg, 7);
    chk("bubble_overflow", ovf_avg, 0);
    tick();

    // All-ones code -> 16 and sticky overflow
    req_one = 1'b1;
    tick();
    do_sample(1'b1, 16'hFFFF, 0);
    chk("ovf_result", res_one, 16);
    chk("ovf_flag", ovf_one, 1);
    tick();
    chk("ovf_sticky", ovf_one, 1);

    // Valid coincident with timer==TIMEOUT-1 wins; new request clears overflow
    snap_rv = n_rv_one;
    req_one = 1'b1;
    tick();
    chk("ovf_cleared", ovf_one, 0);
    do_sample(1'b1, 16'h0003, 19);
    chk("edge_rv", rv_one, 1);
    chk("edge_result", res_one, 2);
    chk("edge_no_timeout", to_one, 0);
    tick();
    chk("edge_rv_count", n_rv_one - snap_rv, 1);

    // ena drop in WAIT aborts without result
    snap_rv = n_rv_avg;
    req_avg = 1'b1;
    tick();
    req_avg = 1'b0;
    tick(); tick(); tick();
    chk("abort_arm_before", arm_avg, 1);
    ena = 1'b0;
    tick();
    chk("abort_arm", arm_avg, 0);
    chk("abort_busy", busy_avg, 0);
    chk("abort_clr", clr_avg, 0);
    chk("abort_timeout", to_avg, 0);
    chk("abort_result", res_avg, 7);
    ena = 1'b1;
    tick();
    chk("abort_no_rv", n_rv_avg - snap_rv, 0);

    // Reset mid-WAIT clears everything, then a new request is accepted
    req_avg = 1'b1;
    tick();
    req_avg = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    chk("mrst_arm", arm_avg, 0);
    chk("mrst_busy", busy_avg, 0);
    chk("mrst_result", res_avg, 0);
    tick();
    rst = 1'b0;
    chk("mrst_result_one", res_one, 0);
    chk("mrst_timeout", to_avg, 0);
    chk("mrst_overflow", ovf_avg, 0);
    chk("mrst_rv", rv_avg, 0);
    tick();
    req_avg = 1'b1;
    tick();
    chk("mrst_accept_busy", busy_avg, 1);
    for (int s = 0; s < 4; s++) do_sample(1'b0, 16'h0003, 0);
    chk("mrst_accept_result", res_avg, 2);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
